// File: rtl/fetch_queue_if.sv
// Fetch-stage bus bundle: instruction-memory request/response and the decode-side valid/ready handshake.
interface fetch_queue_if #(
   parameter int ADDR_W  = 64,
   parameter int INSTR_W = 32
);
   logic               imem_req_F;
   logic [ADDR_W-1:0]  imem_addr_F;
   logic [INSTR_W-1:0] imem_rdata_F;
   logic               instr_valid_D;
   logic               instr_ready_D;
   logic [INSTR_W-1:0] instr_D;
   logic [ADDR_W-1:0]  pc_D;

   modport master (
      output imem_req_F, imem_addr_F, instr_valid_D, instr_D, pc_D,
      input  imem_rdata_F, instr_ready_D
   );

   modport slave (
      input  imem_req_F, imem_addr_F, instr_valid_D, instr_D, pc_D,
      output imem_rdata_F, instr_ready_D
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: sequential PC fetch into a DEPTH-entry buffer with redirect/flush.
// Optional performance counters are enabled by defining FETCH_QUEUE_PERF_EN.
module fetch_queue #(
   parameter int               ADDR_W   = 64,
   parameter int               INSTR_W  = 32,
   parameter int               DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              PCSrc_F,
   input  logic [ADDR_W-1:0] PCBranch_F,
   fetch_queue_if.master     bus,
   output logic [31:0]       perf_fetched,
   output logic [31:0]       perf_flushes
);
   localparam int PTR_W  = $clog2(DEPTH);
   localparam int CNT_W  = PTR_W + 1;
   localparam int LOAD_W = CNT_W + 1;
   localparam logic [LOAD_W-1:0] DEPTH_L = LOAD_W'(DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_FULL = 2'd2;

   logic [1:0]         state, state_n;
   logic [ADDR_W-1:0]  pc, inflight_pc;
   logic               inflight;
   logic [PTR_W-1:0]   wr_ptr, rd_ptr;
   logic [CNT_W-1:0]   count, count_n;
   logic [LOAD_W-1:0]  load_free, load_n;
   logic               pop, push, issue;

   logic [INSTR_W-1:0] instr_mem [DEPTH];
   logic [ADDR_W-1:0]  pc_mem    [DEPTH];

   // A pop this cycle frees a slot for a request issued in the same cycle.
   assign pop       = bus.instr_valid_D & bus.instr_ready_D;
   assign push      = inflight & ~PCSrc_F;
   assign load_free = LOAD_W'(count) + LOAD_W'(inflight) - LOAD_W'(pop);
   assign issue     = (state == S_RUN) & ~PCSrc_F & (load_free < DEPTH_L);
   assign count_n   = count + CNT_W'(push) - CNT_W'(pop);
   assign load_n    = LOAD_W'(count_n) + LOAD_W'(issue);

   assign bus.imem_req_F    = issue;
   assign bus.imem_addr_F   = pc;
   assign bus.instr_valid_D = (count != '0);
   assign bus.instr_D       = instr_mem[rd_ptr];
   assign bus.pc_D          = pc_mem[rd_ptr];

   always_comb begin
      state_n = state;
      case (state)
         S_IDLE:  state_n = S_RUN;
         S_RUN:   if (load_n >= DEPTH_L) state_n = S_FULL;
         S_FULL:  if (load_n < DEPTH_L) state_n = S_RUN;
         default: state_n = S_IDLE;
      endcase
      if (PCSrc_F) state_n = S_RUN;
   end

   // A redirect overrides push, pop and issue: everything buffered or in flight is dropped.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= RESET_PC;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
      end else begin
         state <= state_n;
         if (PCSrc_F) begin
            pc       <= PCBranch_F;
            inflight <= 1'b0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
         end else begin
            count    <= count_n;
            inflight <= issue;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (issue) begin
               inflight_pc <= pc;
               pc          <= pc + ADDR_W'(4);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         instr_mem[wr_ptr] <= bus.imem_rdata_F;
         pc_mem[wr_ptr]    <= inflight_pc;
      end
   end

`ifdef FETCH_QUEUE_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_fetched <= '0;
         perf_flushes <= '0;
      end else if (PCSrc_F) begin
         perf_flushes <= perf_flushes + 32'd1;
      end else if (push) begin
         perf_fetched <= perf_fetched + 32'd1;
      end
   end
`else
   assign perf_fetched = '0;
   assign perf_flushes = '0;
`endif
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed and random steps checked against a queue-based reference model.
module tb_fetch_queue;
   localparam int          ADDR_W   = 64;
   localparam int          INSTR_W  = 32;
   localparam int          DEPTH    = 4;
   localparam logic [63:0] RESET_PC = 64'h0;

   logic        clk = 1'b0;
   logic        reset;
   logic        PCSrc_F;
   logic [63:0] PCBranch_F;
   logic [31:0] perf_fetched, perf_flushes;

   fetch_queue_if #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W)) bus ();

   fetch_queue #(
      .ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
   ) dut (
      .clk(clk), .reset(reset), .PCSrc_F(PCSrc_F), .PCBranch_F(PCBranch_F),
      .bus(bus), .perf_fetched(perf_fetched), .perf_flushes(perf_flushes)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: buffer as queues, plus the single outstanding request.
   logic [63:0] q_pc [$];
   logic [31:0] q_ins [$];
   logic [63:0] m_pc, m_infl_pc;
   bit          m_infl, m_started, m_full, m_req, m_pop;
   int unsigned m_fetched, m_flushes;

   function automatic logic [31:0] memWord(input logic [63:0] a);
      return a[31:0] ^ a[63:32] ^ 32'h9E37_79B9;
   endfunction

   task automatic modelReset();
      q_pc.delete();
      q_ins.delete();
      m_pc      = RESET_PC;
      m_infl    = 1'b0;
      m_infl_pc = '0;
      m_started = 1'b0;
      m_full    = 1'b0;
      m_fetched = 0;
      m_flushes = 0;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkReset();
      checkOutput("rst_req",     64'(bus.imem_req_F), 64'd0);
      checkOutput("rst_addr",    bus.imem_addr_F, RESET_PC);
      checkOutput("rst_valid",   64'(bus.instr_valid_D), 64'd0);
      checkOutput("rst_fetched", 64'(perf_fetched), 64'd0);
      checkOutput("rst_flushes", 64'(perf_flushes), 64'd0);
   endtask

   task automatic checkCycle();
      checkOutput("req", 64'(bus.imem_req_F), 64'(m_req));
      if (m_req) checkOutput("addr", bus.imem_addr_F, m_pc);
      checkOutput("valid", 64'(bus.instr_valid_D), 64'(q_pc.size() > 0));
      if (q_pc.size() > 0) begin
         checkOutput("instr", 64'(bus.instr_D), 64'(q_ins[0]));
         checkOutput("pc_D", bus.pc_D, q_pc[0]);
      end
`ifdef FETCH_QUEUE_PERF_EN
      checkOutput("fetched", 64'(perf_fetched), 64'(m_fetched));
      checkOutput("flushes", 64'(perf_flushes), 64'(m_flushes));
`else
      checkOutput("fetched", 64'(perf_fetched), 64'd0);
      checkOutput("flushes", 64'(perf_flushes), 64'd0);
`endif
   endtask

   task automatic modelUpdate(input bit src, input logic [63:0] tgt, input logic [31:0] rd);
      if (src) begin
         q_pc.delete();
         q_ins.delete();
         m_infl    = 1'b0;
         m_pc      = tgt;
         m_started = 1'b1;
         m_full    = 1'b0;
         m_flushes++;
      end else begin
         if (m_pop) begin
            void'(q_pc.pop_front());
            void'(q_ins.pop_front());
         end
         if (m_infl) begin
            q_pc.push_back(m_infl_pc);
            q_ins.push_back(rd);
            m_fetched++;
         end
         if (m_req) begin
            m_infl    = 1'b1;
            m_infl_pc = m_pc;
            m_pc      = m_pc + 64'd4;
         end else begin
            m_infl = 1'b0;
         end
         m_full    = m_started && ((q_pc.size() + int'(m_infl)) >= DEPTH);
         m_started = 1'b1;
      end
   endtask

   // One clock cycle: drive at the falling edge, check, then advance the model at the rising edge.
   task automatic applyStimulus(input bit src, input logic [63:0] tgt, input bit rdy);
      logic [31:0] rd;
      PCSrc_F           = src;
      PCBranch_F        = tgt;
      bus.instr_ready_D = rdy;
      rd                = m_infl ? memWord(m_infl_pc) : $urandom;
      bus.imem_rdata_F  = rd;
      m_pop = (q_pc.size() > 0) && rdy;
      m_req = m_started && !m_full && !src &&
              ((q_pc.size() + int'(m_infl) - int'(m_pop)) < DEPTH);
      #1;
      checkCycle();
      @(posedge clk);
      modelUpdate(src, tgt, rd);
      @(negedge clk);
   endtask

   initial begin
      reset             = 1'b0;
      PCSrc_F           = 1'b0;
      PCBranch_F        = '0;
      bus.instr_ready_D = 1'b0;
      bus.imem_rdata_F  = '0;
      modelReset();
      @(negedge clk);
      #1 checkReset();
      @(negedge clk);
      reset = 1'b1;

      // Streaming with decode always ready
      for (int i = 0; i < 12; i++) applyStimulus(1'b0, 64'd0, 1'b1);

      // Back-pressure until the buffer fills, then release
      for (int i = 0; i < 10; i++) applyStimulus(1'b0, 64'd0, 1'b0);
      checkOutput("full_req", 64'(bus.imem_req_F), 64'd0);
      checkOutput("full_valid", 64'(bus.instr_valid_D), 64'd1);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 64'd0, 1'b1);

      // Redirect with three buffered entries and one in flight
      reset = 1'b0;
      modelReset();
      @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 5; i++) applyStimulus(1'b0, 64'd0, 1'b0);
      applyStimulus(1'b1, 64'h1000, 1'b1);
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 64'd0, 1'b1);

      // Address wrap at the top of the address space, then back-to-back redirects
      applyStimulus(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 64'd0, 1'b1);
      applyStimulus(1'b1, 64'h2000, 1'b1);
      applyStimulus(1'b1, 64'h3000, 1'b0);
      for (int i = 0; i < 6; i++) applyStimulus(1'b0, 64'd0, 1'b1);

      // Random traffic
      for (int i = 0; i < 300; i++) begin
         bit          s;
         bit          r;
         logic [63:0] t;
         s = ($urandom_range(0, 19) == 0);
         r = ($urandom_range(0, 9) < 7);
         t = {$urandom, $urandom} & ~64'h3;
         applyStimulus(s, t, r);
      end

      // Asynchronous reset with two entries buffered and a request in flight
      applyStimulus(1'b1, 64'h4000, 1'b0);
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 64'd0, 1'b0);
      PCSrc_F = 1'b0;
      #2 reset = 1'b0;
      #1 checkReset();
      modelReset();
      @(negedge clk);
      checkReset();
      reset = 1'b1;
      for (int i = 0; i < 8; i++) applyStimulus(1'b0, 64'd0, 1'b1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter ADDR_W, default 64, PC/address width in bits.
REQ-002 Parameter INSTR_W, default 32, instruction word width.
REQ-003 Parameter DEPTH, default 4, instruction buffer entries; power of two, 2..16.
REQ-004 Parameter RESET_PC, default 0, PC loaded on reset.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  asynchronous, active-low reset (asserted at 0).
REQ-007 PCSrc_F  in  1  redirect request, sampled each rising edge.
REQ-008 PCBranch_F  in  ADDR_W  redirect target, valid when PCSrc_F=1.
REQ-009 imem_req_F  out  1  instruction memory read request this cycle.
REQ-010 imem_addr_F  out  ADDR_W  read address, valid when imem_req_F=1.
REQ-011 imem_rdata_F  in  INSTR_W  read data, valid exactly one cycle after an accepted request.
REQ-012 instr_valid_D  out  1  buffer head is valid.
REQ-013 instr_ready_D  in  1  decode accepts head; transfer when valid and ready are both 1.
REQ-014 instr_D  out  INSTR_W  head instruction.
REQ-015 pc_D  out  ADDR_W  head instruction address.
REQ-016 perf_fetched  out  32  instructions written into the buffer.
REQ-017 perf_flushes  out  32  redirects taken.

Function
REQ-018 FSM states: IDLE (first cycle after reset release, no request), RUN (issuing), FULL (no request, waiting for space); IDLE->RUN unconditionally; RUN->FULL when occupancy+in-flight reaches DEPTH; FULL->RUN when a slot frees or on redirect.
REQ-019 Request issued (imem_req_F=1, imem_addr_F=PC) in RUN only when occupancy + in-flight (0/1) < DEPTH, with the pop this cycle counted as freeing a slot.
REQ-020 PC advances by 4 (ADDR_W modular add, wrap at 2^ADDR_W) on each issued request.
REQ-021 Response one cycle after a request, if not squashed, is written to the buffer tail with its PC; buffer never overflows.
REQ-022 Head presented combinationally from buffer storage; instr_valid_D=1 iff occupancy>0; pop on valid&ready.
REQ-023 Simultaneous push and pop in the same cycle: occupancy unchanged, both take effect.
REQ-024 Redirect (PCSrc_F=1 at an edge): buffer emptied, any in-flight response squashed, PC<=PCBranch_F, no request that cycle, FSM->RUN; a pop in the same cycle is discarded, not counted.
REQ-025 First request after redirect issued the following cycle at PCBranch_F; redirect latency to instr_valid_D=1 is 3 cycles.
REQ-026 Redirect takes priority over push, pop and FULL state.
REQ-027 Consecutive redirects: each one overrides; only the last target is fetched.
REQ-028 Read and write pointers wrap modulo DEPTH; full and empty distinguished by an occupancy count of log2(DEPTH)+1 bits.
REQ-029 perf counters wrap at 2^32; perf_fetched increments per buffer write, perf_flushes per redirect.

Reset
REQ-030 While reset=0: PC=RESET_PC, occupancy=0, in-flight=0, state=IDLE, imem_req_F=0, imem_addr_F=RESET_PC, instr_valid_D=0, perf counters=0.
REQ-031 Reset mid-operation immediately clears all state; in-flight response in the following cycle is ignored.

Configuration
REQ-032 Macro FETCH_QUEUE_PERF_EN: defined -> perf counters implemented per REQ-029; undefined -> no counter flops, perf_fetched and perf_flushes tied to 0, ports still present.

Verification
REQ-033 Reset release, instr_ready_D=1, RESET_PC=0 -> requests at 0,4,8,...; pc_D=0 valid on the third edge after release, then one instruction per cycle.
REQ-034 instr_ready_D=0 held, DEPTH=4 -> exactly 4 requests, state FULL, imem_req_F=0; raise ready -> requests resume next cycle, no loss or duplication.
REQ-035 PCSrc_F=1, PCBranch_F=0x1000 while buffer holds 3 entries and one in flight -> instr_valid_D=0 next cycle, first pc_D=0x1000 three cycles later, stale data never delivered.
REQ-036 PC=2^ADDR_W-4 -> next request address 0.
REQ-037 Reset asserted with 2 entries buffered and request in flight -> all outputs at reset values asynchronously; no write after release.
REQ-038 With FETCH_QUEUE_PERF_EN, 10 deliveries plus 2 redirects -> perf_flushes=2, perf_fetched equals buffer writes; without macro, both read 0.
